// File: rtl/fft_frame_sequencer.sv
// Host-side sequencer for a 2**M-point FFT core. It buffers one frame of samples, drives the
// core's load/start interface, captures the output frame and serves it through a registered read port.
module fft_frame_sequencer #(
    parameter int width   = 16,
    parameter int M       = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [width-1:0] s_data,
    output logic                    fft_load,
    output logic                    fft_start,
    output logic [M-1:0]            fft_adr,
    output logic [2*width-1:0]      fft_rd,
    input  logic                    fft_done,
    input  logic [2*width-1:0]      fft_wd,
    output logic                    frame_ready,
    input  logic [M-1:0]            res_adr,
    output logic [2*width-1:0]      res_data,
    input  logic                    res_ack,
    output logic                    err_timeout
);
    localparam int N  = 2**M;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [M:0]    FULL   = (M+1)'(N);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {FILL, LOAD, START, CAPTURE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [M:0]         wr_cnt_q, wr_cnt_d;
    logic [M:0]         ld_cnt_q, ld_cnt_d;
    logic [M:0]         cap_cnt_q, cap_cnt_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic               err_q, err_d;
    logic [2*width-1:0] in_buf  [N];
    logic [2*width-1:0] res_buf [N];
    logic               accept;
    logic               capture;

    assign accept  = s_valid && s_ready;
    assign capture = (state_q == CAPTURE) && fft_done && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            ld_cnt_q  <= '0;
            cap_cnt_q <= '0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
        end
    end

    // NOTE: the frame buffers carry no reset; every word is written before it is ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            in_buf[wr_cnt_q[M-1:0]] <= {s_data, {width{1'b0}}};
        end
        if (capture) begin
            res_buf[cap_cnt_q[M-1:0]] <= fft_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_data <= '0;
        end else begin
            res_data <= res_buf[res_adr];
        end
    end

    always_comb begin
        // NOTE: every target is defaulted first so no path through the case infers a latch.
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        ld_cnt_d  = ld_cnt_q;
        cap_cnt_d = cap_cnt_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + (M+1)'(1);
                    if (wr_cnt_d == FULL) state_d = LOAD;
                end
            end
            LOAD: begin
                ld_cnt_d = ld_cnt_q + (M+1)'(1);
                if (ld_cnt_d == FULL) state_d = START;
            end
            START: begin
                to_cnt_d = '0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                if (fft_done) begin
                    cap_cnt_d = cap_cnt_q + (M+1)'(1);
                    to_cnt_d  = '0;
                    if (cap_cnt_d == FULL) state_d = HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    // Core stalled: abandon the frame and start collecting a new one.
                    if (to_cnt_d == TO_MAX) begin
                        err_d     = 1'b1;
                        wr_cnt_d  = '0;
                        ld_cnt_d  = '0;
                        cap_cnt_d = '0;
                        to_cnt_d  = '0;
                        state_d   = FILL;
                    end
                end
            end
            HOLD: begin
                if (res_ack) begin
                    wr_cnt_d  = '0;
                    ld_cnt_d  = '0;
                    cap_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs are forced idle while reset is asserted, before the state register catches up.
    always_comb begin
        s_ready     = 1'b0;
        fft_load    = 1'b0;
        fft_start   = 1'b0;
        fft_adr     = '0;
        fft_rd      = '0;
        frame_ready = 1'b0;
        if (!reset) begin
            unique case (state_q)
                FILL:  s_ready = 1'b1;
                LOAD: begin
                    fft_load = 1'b1;
                    fft_adr  = ld_cnt_q[M-1:0];
                    fft_rd   = in_buf[ld_cnt_q[M-1:0]];
                end
                START: fft_start = 1'b1;
                HOLD:  frame_ready = 1'b1;
                default: ;
            endcase
        end
    end

    assign err_timeout = err_q;

endmodule
